// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and default widths for the ID/EX operand stage and its forwarding units.
package id_ex_operand_stage_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_OPCODE_LENGTH  = 4;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// Combinational bypass select for one source operand: MEM beats WB, x0 is never bypassed.
module forward_unit
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0]     stored_data_i,
  input  logic                      mem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic                      wb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output fwd_sel_t                  sel_c_o,
  output logic [DATA_WIDTH-1:0]     data_c_o
);

  logic rs_nonzero;

  assign rs_nonzero = (rs_i != '0);

  always_comb begin
    sel_c_o  = FWD_NONE;
    data_c_o = stored_data_i;
    if (rs_nonzero && mem_reg_write_i && (mem_rd_i == rs_i)) begin
      sel_c_o  = FWD_MEM;
      data_c_o = mem_data_i;
    end else if (rs_nonzero && wb_reg_write_i && (wb_rd_i == rs_i)) begin
      sel_c_o  = FWD_WB;
      data_c_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypassing; stall refreshes stored operands with bypassed values.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned OPCODE_LENGTH  = DEF_OPCODE_LENGTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      IdValid,
  input  logic [DATA_WIDTH-1:0]     IdRs1Data,
  input  logic [DATA_WIDTH-1:0]     IdRs2Data,
  input  logic [DATA_WIDTH-1:0]     IdImm,
  input  logic [REG_ADDR_WIDTH-1:0] IdRs1,
  input  logic [REG_ADDR_WIDTH-1:0] IdRs2,
  input  logic [REG_ADDR_WIDTH-1:0] IdRd,
  input  logic                      IdALUSrc,
  input  logic                      IdRegWrite,
  input  logic [OPCODE_LENGTH-1:0]  IdOperation,
  input  logic                      MemRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MemRd,
  input  logic [DATA_WIDTH-1:0]     MemALUResult,
  input  logic                      WbRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WbRd,
  input  logic [DATA_WIDTH-1:0]     WbResult,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ExValid,
  output logic                      ExRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] ExRd,
  output logic [DATA_WIDTH-1:0]     ExStoreData,
  output logic [1:0]                ForwardA,
  output logic [1:0]                ForwardB
);

  logic                      valid_q,     valid_d;
  logic                      reg_write_q, reg_write_d;
  logic                      alu_src_q,   alu_src_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q,       rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q,       rs2_d;
  logic [OPCODE_LENGTH-1:0]  op_q,        op_d;
  logic [DATA_WIDTH-1:0]     rs1_data_q,  rs1_data_d;
  logic [DATA_WIDTH-1:0]     rs2_data_q,  rs2_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,       imm_d;

  fwd_sel_t              fwd_a_sel, fwd_b_sel;
  logic [DATA_WIDTH-1:0] fwd_a_data, fwd_b_data;

  forward_unit #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_a (
    .rs_i            (rs1_q),
    .stored_data_i   (rs1_data_q),
    .mem_reg_write_i (MemRegWrite),
    .mem_rd_i        (MemRd),
    .mem_data_i      (MemALUResult),
    .wb_reg_write_i  (WbRegWrite),
    .wb_rd_i         (WbRd),
    .wb_data_i       (WbResult),
    .sel_c_o         (fwd_a_sel),
    .data_c_o        (fwd_a_data)
  );

  forward_unit #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_b (
    .rs_i            (rs2_q),
    .stored_data_i   (rs2_data_q),
    .mem_reg_write_i (MemRegWrite),
    .mem_rd_i        (MemRd),
    .mem_data_i      (MemALUResult),
    .wb_reg_write_i  (WbRegWrite),
    .wb_rd_i         (WbRd),
    .wb_data_i       (WbResult),
    .sel_c_o         (fwd_b_sel),
    .data_c_o        (fwd_b_data)
  );

  // Next-state: flush inserts a bubble, stall holds control but refreshes operand data.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    alu_src_d   = alu_src_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_d        = op_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    if (Flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      alu_src_d   = 1'b0;
      rd_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      op_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
    end else if (Stall) begin
      rs1_data_d = fwd_a_data;
      rs2_data_d = fwd_b_data;
    end else begin
      valid_d     = IdValid;
      reg_write_d = IdRegWrite;
      alu_src_d   = IdALUSrc;
      rd_d        = IdRd;
      rs1_d       = IdRs1;
      rs2_d       = IdRs2;
      op_d        = IdOperation;
      rs1_data_d  = IdRs1Data;
      rs2_data_d  = IdRs2Data;
      imm_d       = IdImm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      alu_src_q   <= alu_src_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      op_q        <= op_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
    end
  end

  assign SrcA        = fwd_a_data;
  assign SrcB        = alu_src_q ? imm_q : fwd_b_data;
  assign ExStoreData = fwd_b_data;
  assign Operation   = op_q;
  assign ExValid     = valid_q;
  assign ExRegWrite  = reg_write_q;
  assign ExRd        = rd_q;
  assign ForwardA    = 2'(fwd_a_sel);
  assign ForwardB    = 2'(fwd_b_sel);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_id_ex_operand_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          reset, Stall, Flush, IdValid, IdALUSrc, IdRegWrite;
  logic [DW-1:0] IdRs1Data, IdRs2Data, IdImm;
  logic [RW-1:0] IdRs1, IdRs2, IdRd;
  logic [OW-1:0] IdOperation;
  logic          MemRegWrite, WbRegWrite;
  logic [RW-1:0] MemRd, WbRd;
  logic [DW-1:0] MemALUResult, WbResult;
  logic [DW-1:0] SrcA, SrcB, ExStoreData;
  logic [OW-1:0] Operation;
  logic          ExValid, ExRegWrite;
  logic [RW-1:0] ExRd;
  logic [1:0]    ForwardA, ForwardB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .IdValid(IdValid),
    .IdRs1Data(IdRs1Data), .IdRs2Data(IdRs2Data), .IdImm(IdImm),
    .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd),
    .IdALUSrc(IdALUSrc), .IdRegWrite(IdRegWrite), .IdOperation(IdOperation),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemALUResult(MemALUResult),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbResult(WbResult),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExRd(ExRd), .ExStoreData(ExStoreData),
    .ForwardA(ForwardA), .ForwardB(ForwardB)
  );

  // Behavioural view of the instruction currently held in EX.
  logic          m_valid, m_rw, m_alusrc;
  logic [RW-1:0] m_rd, m_rs1, m_rs2;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_d1, m_d2, m_imm;

  function automatic logic [1:0] exp_sel(input logic [RW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (MemRegWrite && MemRd == rs) return 2'b10;
    if (WbRegWrite && WbRd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] exp_val(input logic [RW-1:0] rs, input logic [DW-1:0] d);
    case (exp_sel(rs))
      2'b10:   return MemALUResult;
      2'b01:   return WbResult;
      default: return d;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_srcb();
    return m_alusrc ? m_imm : exp_val(m_rs2, m_d2);
  endfunction

  // Advance one clock: update the model from the inputs present at the edge, return at negedge.
  task automatic tick();
    logic [DW-1:0] f1, f2;
    f1 = exp_val(m_rs1, m_d1);
    f2 = exp_val(m_rs2, m_d2);
    @(posedge clk);
    if (reset || Flush) begin
      m_valid = 0; m_rw = 0; m_alusrc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_op = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    end else if (Stall) begin
      m_d1 = f1; m_d2 = f2;
    end else begin
      m_valid = IdValid; m_rw = IdRegWrite; m_alusrc = IdALUSrc; m_rd = IdRd;
      m_rs1 = IdRs1; m_rs2 = IdRs2; m_op = IdOperation;
      m_d1 = IdRs1Data; m_d2 = IdRs2Data; m_imm = IdImm;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; Stall = 0; Flush = 0; IdValid = 0; IdALUSrc = 0; IdRegWrite = 0;
    IdRs1Data = 0; IdRs2Data = 0; IdImm = 0; IdRs1 = 0; IdRs2 = 0; IdRd = 0; IdOperation = 0;
    MemRegWrite = 0; MemRd = 0; MemALUResult = 0; WbRegWrite = 0; WbRd = 0; WbResult = 0;
  endtask

  task automatic load(input logic [RW-1:0] rs1, input logic [DW-1:0] d1,
                      input logic [RW-1:0] rs2, input logic [DW-1:0] d2,
                      input logic [OW-1:0] op, input logic alusrc, input logic [DW-1:0] imm);
    IdValid = 1; IdRegWrite = 1; IdRd = 5'd9; IdRs1 = rs1; IdRs1Data = d1;
    IdRs2 = rs2; IdRs2Data = d2; IdOperation = op; IdALUSrc = alusrc; IdImm = imm;
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; Stall = 1; Flush = 1;
    tick(); tick();
    idle_inputs();
    #1;
    checks++;
    if ({ExValid, ExRegWrite, ExRd, Operation, ForwardA, ForwardB} !== '0 ||
        SrcA !== '0 || SrcB !== '0 || ExStoreData !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b rw=%b rd=%0d op=%h fa=%b fb=%b a=%h b=%h sd=%h, required all 0",
               ExValid, ExRegWrite, ExRd, Operation, ForwardA, ForwardB, SrcA, SrcB, ExStoreData);
    end
  endtask

  task automatic test_basic();
    load(5'd1, 32'd5, 5'd2, 32'd7, 4'b0010, 1'b0, 32'h0);
    checks++;
    if (SrcA !== 32'd5 || SrcB !== 32'd7 || Operation !== 4'b0010 || ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      failures++;
      $display("FAIL basic_capture: a=%0d b=%0d op=%b fa=%b fb=%b, required 5 7 0010 00 00",
               SrcA, SrcB, Operation, ForwardA, ForwardB);
    end
    checks++;
    if (ExValid !== 1'b1 || ExRegWrite !== 1'b1 || ExRd !== 5'd9 || ExStoreData !== 32'd7) begin
      failures++;
      $display("FAIL basic_ctrl: valid=%b rw=%b rd=%0d sd=%0d, required 1 1 9 7", ExValid, ExRegWrite, ExRd, ExStoreData);
    end
    load(5'd1, 32'd5, 5'd2, 32'd7, 4'b0110, 1'b1, 32'h1234);
    checks++;
    if (SrcB !== 32'h1234 || ExStoreData !== 32'd7) begin
      failures++;
      $display("FAIL alusrc_imm: b=%h sd=%h, required 1234 7", SrcB, ExStoreData);
    end
  endtask

  task automatic test_fwd_priority();
    load(5'd3, 32'hAA, 5'd6, 32'hBB, 4'b0001, 1'b0, 32'h0);
    MemRegWrite = 1; MemRd = 5'd3; MemALUResult = 32'h11;
    WbRegWrite = 1; WbRd = 5'd3; WbResult = 32'h22;
    #1;
    checks++;
    if (SrcA !== 32'h11 || ForwardA !== 2'b10) begin
      failures++;
      $display("FAIL mem_over_wb: a=%h fa=%b, required 11 10", SrcA, ForwardA);
    end
    MemRd = 5'd7; WbRd = 5'd6;
    #1;
    checks++;
    if (SrcA !== 32'hAA || ForwardA !== 2'b00 || SrcB !== 32'h22 || ForwardB !== 2'b01 || ExStoreData !== 32'h22) begin
      failures++;
      $display("FAIL wb_fwd_b: a=%h fa=%b b=%h fb=%b sd=%h, required aa 00 22 01 22",
               SrcA, ForwardA, SrcB, ForwardB, ExStoreData);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    load(5'd0, 32'h33, 5'd0, 32'h44, 4'b0011, 1'b0, 32'h0);
    MemRegWrite = 1; MemRd = 5'd0; MemALUResult = 32'hFF;
    WbRegWrite = 1; WbRd = 5'd0; WbResult = 32'hEE;
    #1;
    checks++;
    if (SrcB !== 32'h44 || ForwardB !== 2'b00 || SrcA !== 32'h33 || ForwardA !== 2'b00) begin
      failures++;
      $display("FAIL x0_no_fwd: a=%h fa=%b b=%h fb=%b, required 33 00 44 00", SrcA, ForwardA, SrcB, ForwardB);
    end
    idle_inputs();
  endtask

  task automatic test_stall_retire();
    load(5'd4, 32'h10, 5'd8, 32'h20, 4'b0101, 1'b0, 32'h0);
    Stall = 1; IdValid = 1; IdRs1 = 5'd12; IdRs1Data = 32'hDEAD; IdOperation = 4'b1111;
    WbRegWrite = 1; WbRd = 5'd4; WbResult = 32'h99;
    #1;
    checks++;
    if (SrcA !== 32'h99 || ForwardA !== 2'b01) begin
      failures++;
      $display("FAIL stall_cycle1: a=%h fa=%b, required 99 01", SrcA, ForwardA);
    end
    tick();
    WbRegWrite = 0; WbRd = 0; WbResult = 0;
    #1;
    checks++;
    if (SrcA !== 32'h99 || ForwardA !== 2'b00 || Operation !== 4'b0101 || ExStoreData !== 32'h20) begin
      failures++;
      $display("FAIL stall_cycle2: a=%h fa=%b op=%b sd=%h, required 99 00 0101 20", SrcA, ForwardA, Operation, ExStoreData);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (SrcA !== 32'h99 || ExRd !== 5'd9 || ExValid !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold: a=%h rd=%0d valid=%b, required 99 9 1", SrcA, ExRd, ExValid);
    end
  endtask

  task automatic test_flush();
    load(5'd1, 32'h5, 5'd2, 32'h6, 4'b1001, 1'b1, 32'h77);
    Flush = 1; Stall = 1; IdValid = 1; IdRegWrite = 1; IdOperation = 4'b1010; IdRd = 5'd3;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ExValid !== 1'b0 || ExRegWrite !== 1'b0 || Operation !== '0 || ExRd !== '0 || SrcA !== '0 || SrcB !== '0) begin
      failures++;
      $display("FAIL flush_bubble: valid=%b rw=%b op=%b rd=%0d a=%h b=%h, required all 0",
               ExValid, ExRegWrite, Operation, ExRd, SrcA, SrcB);
    end
  endtask

  task automatic test_reset_override();
    load(5'd1, 32'h5, 5'd2, 32'h6, 4'b1001, 1'b1, 32'h77);
    reset = 1; IdValid = 1; IdRegWrite = 1; IdRd = 5'd4; IdRs1 = 5'd5; IdRs1Data = 32'h55; IdOperation = 4'b0111;
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({ExValid, ExRegWrite, ExRd, Operation, ForwardA, ForwardB} !== '0 ||
        SrcA !== '0 || SrcB !== '0 || ExStoreData !== '0) begin
      failures++;
      $display("FAIL reset_override: valid=%b rw=%b rd=%0d op=%h a=%h b=%h, required all 0",
               ExValid, ExRegWrite, ExRd, Operation, SrcA, SrcB);
    end
  endtask

  // Random traffic with small register indices so bypass hits are frequent.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      IdValid = 1'($urandom); IdALUSrc = 1'($urandom); IdRegWrite = 1'($urandom);
      IdRs1Data = $urandom; IdRs2Data = $urandom; IdImm = $urandom;
      IdRs1 = RW'($urandom_range(0, 3)); IdRs2 = RW'($urandom_range(0, 3)); IdRd = RW'($urandom);
      IdOperation = OW'($urandom);
      MemRegWrite = 1'($urandom); MemRd = RW'($urandom_range(0, 3)); MemALUResult = $urandom;
      WbRegWrite = 1'($urandom); WbRd = RW'($urandom_range(0, 3)); WbResult = $urandom;
      #1;
      checks++;
      if (SrcA !== exp_val(m_rs1, m_d1) || SrcB !== exp_srcb() || ExStoreData !== exp_val(m_rs2, m_d2) ||
          ForwardA !== exp_sel(m_rs1) || ForwardB !== exp_sel(m_rs2) || Operation !== m_op ||
          ExValid !== m_valid || ExRegWrite !== m_rw || ExRd !== m_rd) begin
        failures++;
        $display("FAIL random_%0d: a=%h/%h b=%h/%h sd=%h/%h fa=%b/%b fb=%b/%b op=%h/%h v=%b/%b rw=%b/%b rd=%0d/%0d (actual/required)",
                 i, SrcA, exp_val(m_rs1, m_d1), SrcB, exp_srcb(), ExStoreData, exp_val(m_rs2, m_d2),
                 ForwardA, exp_sel(m_rs1), ForwardB, exp_sel(m_rs2), Operation, m_op,
                 ExValid, m_valid, ExRegWrite, m_rw, ExRd, m_rd);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_alusrc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_op = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_fwd_priority();
    test_x0();
    test_stall_retire();
    test_flush();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
